// File: rtl/ddr_iod_ctrl_pkg.sv
// ddr_iod_ctrl_pkg: command encodings, FSM states and width helper for the IOD delay lane controller
package ddr_iod_ctrl_pkg;
  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_STEP = 2'd1,
    OP_SET  = 2'd2,
    OP_EYE  = 2'd3
  } op_e;
  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_DIR,
    S_MOVE,
    S_SETTLE,
    S_EYE_CLR,
    S_EYE_WAIT,
    S_EYE_CAP,
    S_DONE
  } state_e;
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ddr_iod_settle_cnt.sv
// ddr_iod_settle_cnt: loadable down-counter whose done flag marks the last counted cycle
module ddr_iod_settle_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign done = cnt_q == W'(1);
endmodule

// File: rtl/ddr_iod_delay_lane_ctrl.sv
// ddr_iod_delay_lane_ctrl: per-lane IOD delay-line tap tracking, stepping and eye-monitor sampling
module ddr_iod_delay_lane_ctrl
  import ddr_iod_ctrl_pkg::*;
#(
  parameter int NUM_LANES    = 8,
  parameter int TAP_W        = 8,
  parameter int MAX_TAP      = 127,
  parameter int RESET_TAP    = 1,
  parameter int SETTLE_CYC   = 4,
  parameter int EYE_WAIT_CYC = 16
) (
  input  logic                             FAB_CLK,
  input  logic                             SYNC_RST,
  input  logic                             CMD_VALID,
  output logic                             CMD_READY,
  input  logic [1:0]                       CMD_OP,
  input  logic [width_of(NUM_LANES)-1:0]   CMD_LANE,
  input  logic [TAP_W-1:0]                 CMD_ARG,
  output logic                             RSP_VALID,
  output logic                             RSP_ERR,
  output logic                             RSP_EARLY,
  output logic                             RSP_LATE,
  output logic [NUM_LANES*TAP_W-1:0]       TAP_VAL,
  output logic [NUM_LANES-1:0]             DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]             DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0]             DELAY_LINE_LOAD,
  output logic [NUM_LANES-1:0]             EYE_MONITOR_CLEAR_FLAGS,
  input  logic [NUM_LANES-1:0]             DELAY_LINE_OUT_OF_RANGE,
  input  logic [NUM_LANES-1:0]             EYE_MONITOR_EARLY,
  input  logic [NUM_LANES-1:0]             EYE_MONITOR_LATE
);
  localparam int LW = width_of(NUM_LANES);
  localparam int CW = width_of((SETTLE_CYC > EYE_WAIT_CYC ? SETTLE_CYC : EYE_WAIT_CYC) + 1);
  localparam logic [TAP_W-1:0] MAX_T = TAP_W'(MAX_TAP);
  localparam logic [TAP_W-1:0] RST_T = TAP_W'(RESET_TAP);
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [LW-1:0] lane_q, lane_d, cmd_idx;
  logic [TAP_W-1:0] arg_q, arg_d, sel_tap, cmd_tap;
  logic [TAP_W-1:0] tap_q [NUM_LANES];
  logic [TAP_W-1:0] tap_d [NUM_LANES];
  logic inc_q, inc_d, cmd_ok, done_err, cnt_done;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic rsp_early_q, rsp_early_d, rsp_late_q, rsp_late_d;
  logic [NUM_LANES-1:0] lane_oh, move_q, move_d, dir_q, dir_d, load_q, load_d, clr_q, clr_d;
  assign cmd_ok  = int'(CMD_LANE) < NUM_LANES;
  assign cmd_idx = cmd_ok ? CMD_LANE : '0;
  assign cmd_tap = tap_q[cmd_idx];
  assign sel_tap = tap_q[lane_q];
  ddr_iod_settle_cnt #(.W(CW)) u_cnt (
    .clk      (FAB_CLK),
    .rst      (SYNC_RST),
    .load     (state_d != state_q),
    .load_val (state_d == S_EYE_WAIT ? CW'(EYE_WAIT_CYC) : CW'(SETTLE_CYC)),
    .done     (cnt_done)
  );
  // Range errors and no-op SETs are resolved at accept and answered without touching the IOD.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    lane_d      = lane_q;
    arg_d       = arg_q;
    inc_d       = inc_q;
    tap_d       = tap_q;
    rsp_err_d   = rsp_err_q;
    rsp_early_d = rsp_early_q;
    rsp_late_d  = rsp_late_q;
    done_err    = 1'b0;
    case (state_q)
      S_IDLE: if (CMD_VALID) begin
        op_d     = op_e'(CMD_OP);
        lane_d   = cmd_idx;
        arg_d    = CMD_ARG;
        inc_d    = (op_d == OP_SET) ? (CMD_ARG > cmd_tap) : CMD_ARG[0];
        done_err = !cmd_ok || (op_d == OP_STEP && (inc_d ? cmd_tap >= MAX_T : cmd_tap == '0))
                   || (op_d == OP_SET && CMD_ARG > MAX_T);
        state_d  = (done_err || (op_d == OP_SET && CMD_ARG == cmd_tap)) ? S_DONE :
                   op_d == OP_LOAD ? S_LOAD : op_d == OP_EYE ? S_EYE_CLR : S_DIR;
        if (op_d == OP_LOAD && !done_err) tap_d[cmd_idx] = RST_T;
      end
      S_LOAD, S_MOVE: state_d = S_SETTLE;
      S_DIR: begin
        state_d        = S_MOVE;
        tap_d[lane_q]  = inc_q ? sel_tap + TAP_W'(1) : sel_tap - TAP_W'(1);
      end
      S_SETTLE: if (cnt_done) begin
        done_err = DELAY_LINE_OUT_OF_RANGE[lane_q];
        state_d  = (!done_err && op_q == OP_SET && sel_tap != arg_q) ? S_DIR : S_DONE;
        inc_d    = arg_q > sel_tap;
      end
      S_EYE_CLR: state_d = S_EYE_WAIT;
      S_EYE_WAIT: if (cnt_done) state_d = S_EYE_CAP;
      S_EYE_CAP: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DONE && state_q != S_DONE) begin
      rsp_err_d   = done_err;
      rsp_early_d = state_q == S_EYE_CAP && EYE_MONITOR_EARLY[lane_q];
      rsp_late_d  = state_q == S_EYE_CAP && EYE_MONITOR_LATE[lane_q];
    end
    lane_oh     = NUM_LANES'(1) << lane_d;
    load_d      = state_d == S_LOAD ? lane_oh : '0;
    move_d      = state_d == S_MOVE ? lane_oh : '0;
    dir_d       = ((state_d == S_DIR || state_d == S_MOVE) && inc_d) ? lane_oh : '0;
    clr_d       = state_d == S_EYE_CLR ? lane_oh : '0;
    rsp_valid_d = state_d == S_DONE;
  end
  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) begin
      state_q     <= S_IDLE;
      op_q        <= OP_LOAD;
      lane_q      <= '0;
      arg_q       <= '0;
      inc_q       <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) tap_q[i] <= RST_T;
      move_q      <= '0;
      dir_q       <= '0;
      load_q      <= '0;
      clr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_early_q <= 1'b0;
      rsp_late_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      lane_q      <= lane_d;
      arg_q       <= arg_d;
      inc_q       <= inc_d;
      tap_q       <= tap_d;
      move_q      <= move_d;
      dir_q       <= dir_d;
      load_q      <= load_d;
      clr_q       <= clr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_early_q <= rsp_early_d;
      rsp_late_q  <= rsp_late_d;
    end
  end
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_tap
    assign TAP_VAL[g*TAP_W +: TAP_W] = tap_q[g];
  end
  assign CMD_READY               = state_q == S_IDLE;
  assign RSP_VALID               = rsp_valid_q;
  assign RSP_ERR                 = rsp_err_q;
  assign RSP_EARLY               = rsp_early_q;
  assign RSP_LATE                = rsp_late_q;
  assign DELAY_LINE_MOVE         = move_q;
  assign DELAY_LINE_DIRECTION    = dir_q;
  assign DELAY_LINE_LOAD         = load_q;
  assign EYE_MONITOR_CLEAR_FLAGS = clr_q;
endmodule

// File: tb/tb_ddr_iod_delay_lane_ctrl.sv
// tb_ddr_iod_delay_lane_ctrl: randomized self-checking bench against a tap-count reference model
module tb_ddr_iod_delay_lane_ctrl;
  localparam int NL = 8, TW = 8, MAXT = 127, RT = 1, SC = 4, EW = 16;
  localparam int OPL = 0, OPS = 1, OPT = 2, OPE = 3;
  logic FAB_CLK = 1'b0;
  logic SYNC_RST, CMD_VALID, CMD_READY, RSP_VALID, RSP_ERR, RSP_EARLY, RSP_LATE;
  logic [1:0] CMD_OP;
  logic [2:0] CMD_LANE;
  logic [TW-1:0] CMD_ARG;
  logic [NL*TW-1:0] TAP_VAL;
  logic [NL-1:0] MOVE, DIR, LOAD, CLR, OOR, EARLY, LATE;
  int n_vec = 0, n_err = 0;
  int tap_m [NL];
  int obs_lat, obs_moves, obs_loads, obs_clrs, obs_stray, obs_dir_bad, obs_min_gap;
  logic obs_ready1;
  int oor_lane = -1, oor_n = 0;

  ddr_iod_delay_lane_ctrl dut (
    .FAB_CLK(FAB_CLK), .SYNC_RST(SYNC_RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_LANE(CMD_LANE), .CMD_ARG(CMD_ARG), .RSP_VALID(RSP_VALID),
    .RSP_ERR(RSP_ERR), .RSP_EARLY(RSP_EARLY), .RSP_LATE(RSP_LATE), .TAP_VAL(TAP_VAL),
    .DELAY_LINE_MOVE(MOVE), .DELAY_LINE_DIRECTION(DIR), .DELAY_LINE_LOAD(LOAD),
    .EYE_MONITOR_CLEAR_FLAGS(CLR), .DELAY_LINE_OUT_OF_RANGE(OOR),
    .EYE_MONITOR_EARLY(EARLY), .EYE_MONITOR_LATE(LATE)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  function automatic logic [NL*TW-1:0] model_tv();
    logic [NL*TW-1:0] tv;
    for (int i = 0; i < NL; i++) tv[i*TW +: TW] = TW'(tap_m[i]);
    return tv;
  endfunction

  // Issues one command and records what the IOD-facing outputs did until RSP_VALID.
  task automatic run_cmd(input int op, input int lane, input int arg, input logic exp_inc);
    logic [NL-1:0] oh;
    logic prev_dir;
    int prev_move;
    oh = NL'(1) << lane;
    obs_lat = 0; obs_moves = 0; obs_loads = 0; obs_clrs = 0; obs_stray = 0;
    obs_dir_bad = 0; obs_min_gap = 1000; prev_move = -1; prev_dir = 1'b0;
    @(negedge FAB_CLK);
    for (int w = 0; w < 50 && !CMD_READY; w++) @(negedge FAB_CLK);
    CMD_VALID = 1'b1; CMD_OP = 2'(op); CMD_LANE = 3'(lane); CMD_ARG = TW'(arg);
    @(negedge FAB_CLK);
    CMD_VALID = 1'b0;
    obs_ready1 = CMD_READY;
    for (int c = 1; c <= 2000; c++) begin
      if (((MOVE | LOAD | CLR | DIR) & ~oh) != '0) obs_stray++;
      if (LOAD[lane]) obs_loads++;
      if (CLR[lane]) obs_clrs++;
      if (MOVE[lane]) begin
        obs_moves++;
        if (DIR[lane] !== exp_inc || prev_dir !== exp_inc) obs_dir_bad++;
        if (prev_move >= 0 && c - prev_move < obs_min_gap) obs_min_gap = c - prev_move;
        prev_move = c;
        if (lane == oor_lane && obs_moves == oor_n) OOR[lane] = 1'b1;
      end
      prev_dir = DIR[lane];
      if (RSP_VALID) begin obs_lat = c; break; end
      @(negedge FAB_CLK);
    end
  endtask

  task automatic test_reset();
    SYNC_RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = '0; CMD_LANE = '0; CMD_ARG = '0;
    OOR = '0; EARLY = '0; LATE = '0;
    for (int i = 0; i < NL; i++) tap_m[i] = RT;
    repeat (3) @(negedge FAB_CLK);
    SYNC_RST = 1'b0;
    @(negedge FAB_CLK);
    n_vec++; if (CMD_READY !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", CMD_READY); end
    n_vec++; if ({RSP_VALID, RSP_ERR, RSP_EARLY, RSP_LATE} !== 4'b0) begin n_err++; $display("FAIL reset_rsp got %b want 0000", {RSP_VALID, RSP_ERR, RSP_EARLY, RSP_LATE}); end
    n_vec++; if ((MOVE | DIR | LOAD | CLR) !== '0) begin n_err++; $display("FAIL reset_pulses got %h want 0", MOVE | DIR | LOAD | CLR); end
    n_vec++; if (TAP_VAL !== model_tv()) begin n_err++; $display("FAIL reset_taps got %h want %h", TAP_VAL, model_tv()); end
  endtask

  task automatic test_set();
    run_cmd(OPT, 0, 5, 1'b1);
    tap_m[0] = 5;
    n_vec++; if (obs_moves != 4) begin n_err++; $display("FAIL set_moves got %0d want 4", obs_moves); end
    n_vec++; if (obs_dir_bad != 0) begin n_err++; $display("FAIL set_dir got %0d bad moves want 0", obs_dir_bad); end
    n_vec++; if (obs_min_gap < SC + 1) begin n_err++; $display("FAIL set_gap got %0d want >=%0d", obs_min_gap, SC + 1); end
    n_vec++; if (obs_stray != 0) begin n_err++; $display("FAIL set_stray got %0d want 0", obs_stray); end
    n_vec++; if (obs_lat == 0 || RSP_ERR !== 1'b0) begin n_err++; $display("FAIL set_rsp got lat %0d err %b want done err 0", obs_lat, RSP_ERR); end
    n_vec++; if (TAP_VAL !== model_tv()) begin n_err++; $display("FAIL set_tap got %h want %h", TAP_VAL, model_tv()); end
  endtask

  task automatic test_load();
    int t;
    t = 2 + int'($urandom_range(0, 20));
    run_cmd(OPT, 3, t, 1'b1);
    tap_m[3] = t;
    n_vec++; if (TAP_VAL !== model_tv()) begin n_err++; $display("FAIL load_pre_tap got %h want %h", TAP_VAL, model_tv()); end
    run_cmd(OPL, 3, 0, 1'b0);
    tap_m[3] = RT;
    n_vec++; if (obs_ready1 !== 1'b0) begin n_err++; $display("FAIL load_ready_drop got %b want 0", obs_ready1); end
    n_vec++; if (obs_loads != 1) begin n_err++; $display("FAIL load_pulses got %0d want 1", obs_loads); end
    n_vec++; if (obs_lat != SC + 2) begin n_err++; $display("FAIL load_latency got %0d want %0d", obs_lat, SC + 2); end
    n_vec++; if (RSP_ERR !== 1'b0 || obs_moves != 0 || obs_stray != 0) begin n_err++; $display("FAIL load_clean got err %b moves %0d stray %0d want 0 0 0", RSP_ERR, obs_moves, obs_stray); end
    n_vec++; if (TAP_VAL !== model_tv()) begin n_err++; $display("FAIL load_tap got %h want %h", TAP_VAL, model_tv()); end
    @(negedge FAB_CLK);
    n_vec++; if (RSP_VALID !== 1'b0) begin n_err++; $display("FAIL load_rsp_pulse got %b want 0", RSP_VALID); end
  endtask

  task automatic test_range();
    run_cmd(OPT, 2, 0, 1'b0);
    tap_m[2] = 0;
    n_vec++; if (TAP_VAL !== model_tv() || obs_moves != 1) begin n_err++; $display("FAIL range_to0 got %h moves %0d want %h 1", TAP_VAL, obs_moves, model_tv()); end
    run_cmd(OPS, 2, 0, 1'b0);
    n_vec++; if (obs_moves != 0 || RSP_ERR !== 1'b1) begin n_err++; $display("FAIL range_dec0 got moves %0d err %b want 0 1", obs_moves, RSP_ERR); end
    n_vec++; if (TAP_VAL !== model_tv()) begin n_err++; $display("FAIL range_dec0_tap got %h want %h", TAP_VAL, model_tv()); end
    run_cmd(OPT, 2, 200, 1'b1);
    n_vec++; if (obs_moves != 0 || RSP_ERR !== 1'b1 || TAP_VAL !== model_tv()) begin n_err++; $display("FAIL range_set200 got moves %0d err %b tap %h", obs_moves, RSP_ERR, TAP_VAL); end
    run_cmd(OPT, 2, 0, 1'b0);
    n_vec++; if (obs_lat != 1 || obs_moves != 0 || RSP_ERR !== 1'b0) begin n_err++; $display("FAIL range_set_same got lat %0d moves %0d err %b want 1 0 0", obs_lat, obs_moves, RSP_ERR); end
    run_cmd(OPT, 6, MAXT, 1'b1);
    tap_m[6] = MAXT;
    n_vec++; if (obs_moves != MAXT - RT || TAP_VAL !== model_tv()) begin n_err++; $display("FAIL range_tomax got moves %0d tap %h", obs_moves, TAP_VAL); end
    run_cmd(OPS, 6, 1, 1'b1);
    n_vec++; if (obs_moves != 0 || RSP_ERR !== 1'b1 || TAP_VAL !== model_tv()) begin n_err++; $display("FAIL range_incmax got moves %0d err %b", obs_moves, RSP_ERR); end
    run_cmd(OPS, 6, 0, 1'b0);
    tap_m[6] = MAXT - 1;
    n_vec++; if (obs_moves != 1 || RSP_ERR !== 1'b0 || TAP_VAL !== model_tv() || obs_dir_bad != 0) begin n_err++; $display("FAIL range_decmax got moves %0d err %b dirbad %0d", obs_moves, RSP_ERR, obs_dir_bad); end
  endtask

  task automatic test_oor();
    oor_lane = 1; oor_n = 3;
    run_cmd(OPT, 1, 10, 1'b1);
    tap_m[1] = RT + 3;
    n_vec++; if (obs_moves != 3 || RSP_ERR !== 1'b1) begin n_err++; $display("FAIL oor_stop got moves %0d err %b want 3 1", obs_moves, RSP_ERR); end
    n_vec++; if (TAP_VAL !== model_tv()) begin n_err++; $display("FAIL oor_tap got %h want %h", TAP_VAL, model_tv()); end
    oor_lane = -1; OOR = '0;
  endtask

  task automatic test_eye();
    logic [NL-1:0] e, l;
    EARLY = NL'($urandom) | 8'h20; LATE = NL'($urandom) & ~8'h20;
    run_cmd(OPE, 5, 0, 1'b0);
    n_vec++; if (obs_clrs != 1 || obs_stray != 0) begin n_err++; $display("FAIL eye_clear got %0d stray %0d want 1 0", obs_clrs, obs_stray); end
    n_vec++; if (obs_lat != EW + 3) begin n_err++; $display("FAIL eye_latency got %0d want %0d", obs_lat, EW + 3); end
    n_vec++; if ({RSP_EARLY, RSP_LATE, RSP_ERR} !== 3'b100) begin n_err++; $display("FAIL eye_flags got %b want 100", {RSP_EARLY, RSP_LATE, RSP_ERR}); end
    repeat (3) @(negedge FAB_CLK);
    n_vec++; if (RSP_VALID !== 1'b0 || RSP_EARLY !== 1'b1) begin n_err++; $display("FAIL eye_hold got valid %b early %b want 0 1", RSP_VALID, RSP_EARLY); end
    for (int k = 0; k < 4; k++) begin
      int ln;
      ln = int'($urandom_range(0, NL - 1));
      e = NL'($urandom); l = NL'($urandom);
      EARLY = e; LATE = l;
      run_cmd(OPE, ln, 0, 1'b0);
      n_vec++; if ({RSP_EARLY, RSP_LATE} !== {e[ln], l[ln]} || obs_clrs != 1) begin n_err++; $display("FAIL eye_rand lane %0d got %b want %b", ln, {RSP_EARLY, RSP_LATE}, {e[ln], l[ln]}); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      int ln, op, arg, tgt, exp_moves;
      logic exp_err, inc;
      ln = int'($urandom_range(0, NL - 1));
      op = int'($urandom_range(0, 2));
      exp_moves = 0; exp_err = 1'b0; inc = 1'b0; arg = 0;
      if (op == OPL) begin
        tap_m[ln] = RT;
      end else if (op == OPS) begin
        inc = 1'($urandom);
        arg = int'($urandom_range(0, 255) & 254) | int'(inc);
        exp_err = inc ? tap_m[ln] == MAXT : tap_m[ln] == 0;
        if (!exp_err) begin exp_moves = 1; tap_m[ln] += inc ? 1 : -1; end
      end else begin
        tgt = tap_m[ln] + int'($urandom_range(0, 12)) - 6;
        if (tgt < 0) tgt = 0;
        if ($urandom_range(0, 7) == 0) tgt = int'($urandom_range(MAXT + 1, 255));
        arg = tgt;
        inc = tgt > tap_m[ln];
        exp_err = tgt > MAXT;
        if (!exp_err) begin exp_moves = inc ? tgt - tap_m[ln] : tap_m[ln] - tgt; tap_m[ln] = tgt; end
      end
      run_cmd(op, ln, arg, inc);
      n_vec++; if (obs_lat == 0 || RSP_ERR !== exp_err || obs_moves != exp_moves) begin n_err++; $display("FAIL rand%0d op %0d lane %0d got lat %0d err %b moves %0d want err %b moves %0d", k, op, ln, obs_lat, RSP_ERR, obs_moves, exp_err, exp_moves); end
      n_vec++; if (TAP_VAL !== model_tv() || obs_stray != 0 || obs_dir_bad != 0) begin n_err++; $display("FAIL rand%0d_tap got %h stray %0d dirbad %0d want %h", k, TAP_VAL, obs_stray, obs_dir_bad, model_tv()); end
    end
  endtask

  task automatic test_reset_mid();
    int rsp_seen;
    @(negedge FAB_CLK);
    for (int w = 0; w < 50 && !CMD_READY; w++) @(negedge FAB_CLK);
    CMD_VALID = 1'b1; CMD_OP = 2'(OPT); CMD_LANE = 3'd0;
    CMD_ARG = TW'(tap_m[0] + 40 > MAXT ? tap_m[0] - 40 : tap_m[0] + 40);
    @(negedge FAB_CLK);
    CMD_VALID = 1'b0;
    repeat (14) @(negedge FAB_CLK);
    SYNC_RST = 1'b1;
    @(negedge FAB_CLK);
    for (int i = 0; i < NL; i++) tap_m[i] = RT;
    n_vec++; if ((MOVE | DIR | LOAD | CLR) !== '0 || CMD_READY !== 1'b1) begin n_err++; $display("FAIL rstmid_outs got pulses %h ready %b want 0 1", MOVE | DIR | LOAD | CLR, CMD_READY); end
    n_vec++; if (TAP_VAL !== model_tv() || RSP_VALID !== 1'b0) begin n_err++; $display("FAIL rstmid_taps got %h valid %b want %h 0", TAP_VAL, RSP_VALID, model_tv()); end
    SYNC_RST = 1'b0;
    rsp_seen = 0;
    repeat (10) begin @(negedge FAB_CLK); if (RSP_VALID) rsp_seen++; end
    n_vec++; if (rsp_seen != 0) begin n_err++; $display("FAIL rstmid_norsp got %0d responses want 0", rsp_seen); end
  endtask

  initial begin
    test_reset();
    test_set();
    test_load();
    test_range();
    test_oor();
    test_eye();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
